// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl
//   SPI master that runs one full-duplex word per start request. The word
//   width, SCLK half-period and chip-select count are parameters. SPI mode
//   (CPOL/CPHA) and bit order are captured per transaction on the accept cycle.
//
// Ports
//   clk_i        system clock, rising edge
//   rst_n_i      asynchronous active-low reset
//   start_i      transaction request, accepted only while idle
//   data_in_bi   word to transmit (sampled on accept)
//   cs_sel_bi    slave index (sampled on accept); out-of-range selects none
//   cpol_i       SCLK idle level (sampled on accept, followed while idle)
//   cpha_i       0: sample on leading edge, 1: sample on trailing edge
//   lsb_first_i  0: MSB first, 1: LSB first (TX and RX)
//   busy_o       high from the cycle after accept until the done cycle
//   done_o       one-cycle pulse when data_out_bo is updated
//   data_out_bo  last received word
//   spi_sclk_o   SPI clock
//   spi_mosi_o   master out / slave in
//   spi_miso_i   master in / slave out
//   spi_cs_no    active-low chip selects, at most one low
module spi_master_ctrl #(
  parameter int DATA_W   = 8,
  parameter int CLK_DIV  = 2,
  parameter int NUM_CS   = 4,
  parameter int CS_SEL_W = 2
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                start_i,
  input  logic [DATA_W-1:0]   data_in_bi,
  input  logic [CS_SEL_W-1:0] cs_sel_bi,
  input  logic                cpol_i,
  input  logic                cpha_i,
  input  logic                lsb_first_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [DATA_W-1:0]   data_out_bo,
  output logic                spi_sclk_o,
  output logic                spi_mosi_o,
  input  logic                spi_miso_i,
  output logic [NUM_CS-1:0]   spi_cs_no
);

  localparam int EW = $clog2(2*DATA_W+1);  // edge counter width
  localparam int DW = $clog2(CLK_DIV+1);   // half-period counter width
  localparam int IW = $clog2(DATA_W);      // bit index width

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

  state_t            state;
  logic [DW-1:0]     div_cnt;
  logic [EW-1:0]     edge_cnt;
  logic [DATA_W-1:0] tx_word;
  logic [DATA_W-1:0] rx_word;
  logic              cpha_lat;
  logic              lsb_lat;

  // Chip-select pattern for the requested slave; an index beyond NUM_CS
  // matches no bit, so every select stays high.
  logic [NUM_CS-1:0] cs_dec;
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CS; gi++) begin : g_cs_dec
      assign cs_dec[gi] = (cs_sel_bi != CS_SEL_W'(gi));
    end
  endgenerate

  logic          div_wrap;
  logic [EW-1:0] k_next;      // number of the SCLK edge produced on a wrap
  logic          last_edge;
  logic          drive_now;
  logic          sample_now;
  logic [IW-1:0] drive_i;
  logic [IW-1:0] sample_i;
  logic [IW-1:0] drive_pos;
  logic [IW-1:0] sample_pos;
  logic [IW-1:0] first_pos;

  always_comb begin
    div_wrap  = (div_cnt == DW'(CLK_DIV-1));
    k_next    = edge_cnt + EW'(1);
    last_edge = (k_next == EW'(2*DATA_W));
    // CPHA=0 drives on even edges (bit 0 is already out before edge 1) and
    // has nothing left to drive on the final edge; CPHA=1 drives on odd edges.
    drive_now  = cpha_lat ? k_next[0] : (~k_next[0] & ~last_edge);
    sample_now = cpha_lat ? ~k_next[0] : k_next[0];
    // floor(k/2) is the bit number driven on edge k in both modes, and the
    // bit sampled on edge k for CPHA=0; CPHA=1 samples one bit behind that.
    drive_i    = IW'(k_next >> 1);
    sample_i   = cpha_lat ? (IW'(k_next >> 1) - IW'(1)) : IW'(k_next >> 1);
    drive_pos  = lsb_lat ? drive_i  : IW'(DATA_W-1) - drive_i;
    sample_pos = lsb_lat ? sample_i : IW'(DATA_W-1) - sample_i;
    first_pos  = lsb_first_i ? '0 : IW'(DATA_W-1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= IDLE;
      div_cnt     <= '0;
      edge_cnt    <= '0;
      tx_word     <= '0;
      rx_word     <= '0;
      cpha_lat    <= 1'b0;
      lsb_lat     <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      data_out_bo <= '0;
      spi_sclk_o  <= 1'b0;
      spi_mosi_o  <= 1'b0;
      spi_cs_no   <= '1;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          spi_sclk_o <= cpol_i;
          spi_mosi_o <= 1'b0;
          spi_cs_no  <= '1;
          div_cnt    <= '0;
          edge_cnt   <= '0;
          if (start_i) begin
            state      <= SETUP;
            busy_o     <= 1'b1;
            spi_cs_no  <= cs_dec;
            tx_word    <= data_in_bi;
            cpha_lat   <= cpha_i;
            lsb_lat    <= lsb_first_i;
            spi_mosi_o <= cpha_i ? 1'b0 : data_in_bi[first_pos];
          end
        end
        SETUP, XFER: begin
          state <= XFER;
          if (div_wrap) begin
            div_cnt    <= '0;
            edge_cnt   <= k_next;
            spi_sclk_o <= ~spi_sclk_o;
            if (drive_now)
              spi_mosi_o <= tx_word[drive_pos];
            // MISO is captured on the same clock edge that moves SCLK.
            if (sample_now)
              rx_word[sample_pos] <= spi_miso_i;
            if (last_edge)
              state <= HOLD;
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        HOLD: begin
          if (div_wrap) begin
            state       <= IDLE;
            div_cnt     <= '0;
            edge_cnt    <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b1;
            data_out_bo <= rx_word;
            spi_cs_no   <= '1;
            spi_mosi_o  <= 1'b0;
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: an 8-bit / divide-by-2 instance driven through
// directed and random transactions against a behavioural SPI slave, plus a
// 16-bit / divide-by-1 instance run back-to-back with start held high.
module tb_spi_master_ctrl;

  localparam int DW8  = 8;
  localparam int CD8  = 2;
  localparam int LAT8 = 1 + (2*DW8+1)*CD8;
  localparam int LAT16 = 1 + (2*16+1)*1;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] din;
  logic [1:0] sel;
  logic       cpol, cpha, lsb;
  logic       busy, done;
  logic [7:0] dout;
  logic       sclk, mosi, miso;
  logic [3:0] cs_n;

  logic        start16;
  logic [15:0] din16;
  logic [1:0]  sel16;
  logic        cpol16, cpha16, lsb16;
  logic        busy16, done16;
  logic [15:0] dout16;
  logic        sclk16, mosi16, miso16;
  logic [3:0]  cs16;

  int tests_run = 0;
  int tests_failed = 0;

  // behavioural slave state
  logic       loop_en = 1'b0;
  logic       slv_miso = 1'b0;
  logic [7:0] slv_tx = '0;
  logic [7:0] slv_rx = '0;
  logic       slv_cpol = 1'b0, slv_cpha = 1'b0, slv_lsb = 1'b0;
  int         s_tx_i = 0, s_rx_i = 0;
  logic       prev_sclk = 1'b0, prev_mosi = 1'b0, prev_act = 1'b0;
  int         rise_cnt = 0, fall_cnt = 0, mosi_bad = 0;

  assign miso   = loop_en ? mosi : slv_miso;
  assign miso16 = mosi16;

  spi_master_ctrl #(.DATA_W(8), .CLK_DIV(2), .NUM_CS(4), .CS_SEL_W(2)) u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .data_in_bi(din),
    .cs_sel_bi(sel), .cpol_i(cpol), .cpha_i(cpha), .lsb_first_i(lsb),
    .busy_o(busy), .done_o(done), .data_out_bo(dout),
    .spi_sclk_o(sclk), .spi_mosi_o(mosi), .spi_miso_i(miso), .spi_cs_no(cs_n)
  );

  spi_master_ctrl #(.DATA_W(16), .CLK_DIV(1), .NUM_CS(4), .CS_SEL_W(2)) u_dut16 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start16), .data_in_bi(din16),
    .cs_sel_bi(sel16), .cpol_i(cpol16), .cpha_i(cpha16), .lsb_first_i(lsb16),
    .busy_o(busy16), .done_o(done16), .data_out_bo(dout16),
    .spi_sclk_o(sclk16), .spi_mosi_o(mosi16), .spi_miso_i(miso16), .spi_cs_no(cs16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] bit_pos(input int i, input logic l);
    return l ? 3'(i) : 3'(7 - i);
  endfunction

  // SPI slave: shifts on its drive edge, captures MOSI on its sample edge,
  // observed mid-cycle so it reacts after the master's clock edge.
  always @(negedge clk) begin
    logic act, leading;
    act = (cs_n != 4'hF);
    if (act && !prev_act) begin
      s_tx_i = 0;
      s_rx_i = 0;
      if (!slv_cpha) begin
        slv_miso = slv_tx[bit_pos(0, slv_lsb)];
        s_tx_i = 1;
      end
    end
    if (act && sclk != prev_sclk) begin
      if (sclk) rise_cnt++; else fall_cnt++;
      leading = (sclk != slv_cpol);
      if (leading ^ slv_cpha) begin
        if (s_rx_i < 8) slv_rx[bit_pos(s_rx_i, slv_lsb)] = mosi;
        s_rx_i++;
      end else begin
        if (s_tx_i < 8) slv_miso = slv_tx[bit_pos(s_tx_i, slv_lsb)];
        s_tx_i++;
      end
    end
    if (act && prev_act && mosi != prev_mosi && !(prev_sclk && !sclk))
      mosi_bad++;
    prev_sclk = sclk;
    prev_mosi = mosi;
    prev_act  = act;
  end

  // One transaction on the 8-bit instance. poke_at re-raises start mid-word;
  // abort_at drops reset mid-word and checks the asynchronous reset values.
  task automatic run_xfer(input logic [7:0] d, input logic [1:0] s, input logic p,
                          input logic h, input logic l, input logic [7:0] sw,
                          input logic lp, input int poke_at, input int abort_at);
    int n, cs_bad, busy_bad;
    logic [3:0] exp_cs;
    logic exp_b0;
    cpol = p; cpha = h; lsb = l;
    slv_cpol = p; slv_cpha = h; slv_lsb = l; slv_tx = sw; loop_en = lp;
    @(posedge clk); #1;
    rise_cnt = 0; fall_cnt = 0; mosi_bad = 0; slv_rx = '0;
    din = d; sel = s; start = 1'b1;
    exp_b0 = l ? d[0] : d[7];
    exp_cs = 4'hF & ~(4'b0001 << s);
    @(posedge clk); #1;
    start = 1'b0;
    n = 1; cs_bad = 0; busy_bad = 0;
    while (!done && n < 200) begin
      if (n == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_dout", 32'(dout), 32'd0);
        check_eq("rst_sclk", 32'(sclk), 32'd0);
        check_eq("rst_mosi", 32'(mosi), 32'd0);
        check_eq("rst_cs", 32'(cs_n), 32'hF);
        $display("[TB] xfer d=%02h aborted by reset at cycle %0d", d, n);
        return;
      end
      if (n == 1) check_eq("mosi_t0", 32'(mosi), 32'(h ? 1'b0 : exp_b0));
      if (n == CD8 + 1) check_eq("mosi_b0", 32'(mosi), 32'(exp_b0));
      if (cs_n !== exp_cs) cs_bad++;
      if (busy !== 1'b1) busy_bad++;
      if (n == poke_at) begin start = 1'b1; din = ~d; end
      if (n == poke_at + 1) begin start = 1'b0; din = d; end
      @(posedge clk); #1;
      n++;
    end
    check_eq("latency", 32'(n), 32'(LAT8));
    check_eq("dout", 32'(dout), 32'(lp ? d : sw));
    check_eq("slave_rx", 32'(slv_rx), 32'(d));
    check_eq("sclk_rises", 32'(rise_cnt), 32'(DW8));
    check_eq("sclk_falls", 32'(fall_cnt), 32'(DW8));
    check_eq("cs_during", 32'(cs_bad), 32'd0);
    check_eq("busy_during", 32'(busy_bad), 32'd0);
    check_eq("cs_at_done", 32'(cs_n), 32'hF);
    check_eq("busy_at_done", 32'(busy), 32'd0);
    check_eq("sclk_idle", 32'(sclk), 32'(p));
    $display("[TB] xfer d=%02h sel=%0d mode=%0d lsb=%0d loop=%0d dout=%02h cycles=%0d",
             d, s, {p, h}, l, lp, dout, n);
    @(posedge clk); #1;
    check_eq("done_pulse", 32'(done), 32'd0);
  endtask

  initial begin
    int extra, n;
    logic [15:0] exp16;
    logic [3:0]  exp_cs16;
    rst_n = 1'b0; start = 1'b0; din = '0; sel = '0; cpol = 1'b0; cpha = 1'b0; lsb = 1'b0;
    start16 = 1'b0; din16 = '0; sel16 = '0; cpol16 = 1'b0; cpha16 = 1'b0; lsb16 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_busy", 32'(busy), 32'd0);
    check_eq("reset_done", 32'(done), 32'd0);
    check_eq("reset_dout", 32'(dout), 32'd0);
    check_eq("reset_sclk", 32'(sclk), 32'd0);
    check_eq("reset_mosi", 32'(mosi), 32'd0);
    check_eq("reset_cs", 32'(cs_n), 32'hF);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // mode 0 loopback
    run_xfer(8'hA5, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 0, 0);

    // mode 3 with a slave answering 0x3C
    cpol = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("cpol1_idle", 32'(sclk), 32'd1);
    run_xfer(8'hC3, 2'd1, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b0, 0, 0);
    check_eq("mode3_mosi_fall", 32'(mosi_bad), 32'd0);

    // LSB-first, mode 1 loopback
    run_xfer(8'h01, 2'd1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 0, 0);

    // CS 2 with a second start raised mid-transfer
    run_xfer(8'h5A, 2'd2, 1'b0, 1'b0, 1'b0, 8'h96, 1'b0, 10, 0);
    extra = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    check_eq("single_done", 32'(extra), 32'd0);

    // reset during bit 4, then a clean transfer
    run_xfer(8'h77, 2'd3, 1'b1, 1'b0, 1'b0, 8'hE1, 1'b0, 0, 19);
    @(posedge clk); #1;
    check_eq("rst_hold_cs", 32'(cs_n), 32'hF);
    rst_n = 1'b1;
    extra = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    check_eq("no_done_after_rst", 32'(extra), 32'd0);
    run_xfer(8'h9C, 2'd3, 1'b0, 1'b0, 1'b0, 8'h4B, 1'b0, 0, 0);

    // random transactions
    for (int i = 0; i < 20; i++) begin
      run_xfer(8'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
               1'($urandom_range(0, 1)), 0, 0);
    end

    // 16-bit, divide-by-1, start held high: back-to-back loopback words
    din16 = 16'($urandom); sel16 = 2'($urandom_range(0, 3));
    cpol16 = 1'($urandom_range(0, 1)); cpha16 = 1'($urandom_range(0, 1));
    lsb16 = 1'($urandom_range(0, 1));
    exp16 = din16;
    exp_cs16 = 4'hF & ~(4'b0001 << sel16);
    start16 = 1'b1;
    n = 0;
    for (int w = 0; w < 6; w++) begin
      do begin
        @(posedge clk); #1;
        n++;
        if (n == 1) check_eq("b2b_cs_low", 32'(cs16), 32'(exp_cs16));
      end while (!done16 && n < 100);
      check_eq("b2b_latency", 32'(n), 32'(LAT16));
      check_eq("b2b_data", 32'(dout16), 32'(exp16));
      check_eq("b2b_cs_gap", 32'(cs16), 32'hF);
      check_eq("b2b_busy", 32'(busy16), 32'd0);
      $display("[TB] b2b word %0d d=%04h dout=%04h cycles=%0d", w, exp16, dout16, n);
      din16 = 16'($urandom); sel16 = 2'($urandom_range(0, 3));
      cpol16 = 1'($urandom_range(0, 1)); cpha16 = 1'($urandom_range(0, 1));
      lsb16 = 1'($urandom_range(0, 1));
      exp16 = din16;
      exp_cs16 = 4'hF & ~(4'b0001 << sel16);
      n = 0;
    end
    start16 = 1'b0;
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
